// File: rtl/lsu_riscv.sv
// Load-store unit: turns decoder memory controls into a req/gnt/rvalid bus access,
// with byte-enable/write-data formatting, load extension, legality checks and a timeout.
module lsu_riscv #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_fault_o,
    output logic [1:0]  lsu_fault_code_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_rvalid_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt;

    logic        illegal, misaligned, req_fault, done, timeout_now;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        illegal    = (lsu_size_i == 3'd3) || (lsu_size_i == 3'd6) || (lsu_size_i == 3'd7) ||
                     (lsu_size_i[2] && lsu_we_i);
        misaligned = ((lsu_size_i[1:0] == 2'd1) && lsu_addr_i[0]) ||
                     ((lsu_size_i[1:0] == 2'd2) && (lsu_addr_i[1:0] != 2'd0));
        req_fault  = (state == S_IDLE) && lsu_req_i && (illegal || misaligned);

        case (lsu_size_i[1:0])
            2'd0:    be_new = 4'b0001 << lsu_addr_i[1:0];
            2'd1:    be_new = 4'b0011 << {lsu_addr_i[1], 1'b0};
            default: be_new = 4'b1111;
        endcase
        case (lsu_size_i[1:0])
            2'd0:    wdata_new = {4{lsu_data_i[7:0]}};
            2'd1:    wdata_new = {2{lsu_data_i[15:0]}};
            default: wdata_new = lsu_data_i;
        endcase

        // rvalid is only meaningful in WAIT, or in REQ alongside gnt
        done = !rst_i && (((state == S_REQ) && data_gnt_i && (we_q || data_rvalid_i)) ||
                          ((state == S_WAIT) && data_rvalid_i));
        timeout_now = !rst_i && (state != S_IDLE) && (cnt == 8'(TIMEOUT - 1)) && !done;

        case (off_q)
            2'd0:    rd_byte = data_rdata_i[7:0];
            2'd1:    rd_byte = data_rdata_i[15:8];
            2'd2:    rd_byte = data_rdata_i[23:16];
            default: rd_byte = data_rdata_i[31:24];
        endcase
        rd_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (size_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    load_ext = {24'd0, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd5:    load_ext = {16'd0, rd_half};
            default: load_ext = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= 8'd0;
                    if (lsu_req_i && !illegal && !misaligned) begin
                        we_q    <= lsu_we_i;
                        size_q  <= lsu_size_i;
                        off_q   <= lsu_addr_i[1:0];
                        addr_q  <= {lsu_addr_i[31:2], 2'b00};
                        wdata_q <= wdata_new;
                        be_q    <= be_new;
                        state   <= S_REQ;
                    end
                end
                default: begin
                    if (done || timeout_now) begin
                        state <= S_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if ((state == S_REQ) && data_gnt_i) state <= S_WAIT;
                    end
                end
            endcase
        end
    end

    assign data_req_o   = (state == S_REQ);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

    assign lsu_data_o       = (done && !we_q) ? load_ext : 32'd0;
    assign lsu_fault_o      = !rst_i && (req_fault || timeout_now);
    assign lsu_fault_code_o = rst_i       ? 2'd0 :
                              timeout_now ? 2'd3 :
                              !req_fault  ? 2'd0 :
                              illegal     ? 2'd2 : 2'd1;
    assign lsu_stall_req_o  = lsu_req_i && !rst_i && !done && !req_fault && !timeout_now;

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv: loads, stores, faults, gnt delay, timeout, reset and back-to-back.
module tb_lsu_riscv;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wd;
    logic [31:0] lsu_data;
    logic        lsu_stall, lsu_fault;
    logic [1:0]  lsu_code;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    lsu_riscv #(.TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
        .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wd), .lsu_data_o(lsu_data),
        .lsu_stall_req_o(lsu_stall), .lsu_fault_o(lsu_fault), .lsu_fault_code_o(lsu_code),
        .data_req_o(d_req), .data_we_o(d_we), .data_be_o(d_be), .data_addr_o(d_addr),
        .data_wdata_o(d_wdata), .data_gnt_i(d_gnt), .data_rdata_i(d_rdata),
        .data_rvalid_i(d_rvalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs after the falling edge, then settles before checks.
    task automatic cyc(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        lsu_req = req; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wd = wd;
        d_gnt = gnt; d_rvalid = rv; d_rdata = rd;
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(d_req), 32'd0);
        check({tag, "_we"},    32'(d_we), 32'd0);
        check({tag, "_be"},    32'(d_be), 32'd0);
        check({tag, "_addr"},  d_addr, 32'd0);
        check({tag, "_wdata"}, d_wdata, 32'd0);
        check({tag, "_fault"}, 32'(lsu_fault), 32'd0);
        check({tag, "_code"},  32'(lsu_code), 32'd0);
        check({tag, "_data"},  lsu_data, 32'd0);
        check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_cyc();
        idle_cyc();
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        idle_cyc();

        // LB 0x103, gnt immediate, rvalid one cycle later
        cyc(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1'b0, 1'b0, 32'd0);
        check("lb_acc_stall", 32'(lsu_stall), 32'd1);
        check("lb_acc_req", 32'(d_req), 32'd0);
        cyc(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1'b1, 1'b0, 32'd0);
        check("lb_req", 32'(d_req), 32'd1);
        check("lb_be", 32'(d_be), 32'h8);
        check("lb_addr", d_addr, 32'h100);
        check("lb_we", 32'(d_we), 32'd0);
        check("lb_req_stall", 32'(lsu_stall), 32'd1);
        cyc(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1'b0, 1'b1, 32'h80AA_BBCC);
        check("lb_wait_req", 32'(d_req), 32'd0);
        check("lb_data", lsu_data, 32'hFFFF_FF80);
        check("lb_done_stall", 32'(lsu_stall), 32'd0);
        idle_cyc();
        check("lb_after_data", lsu_data, 32'd0);

        // SH 0x202
        cyc(1'b1, 1'b1, 3'd1, 32'h202, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        check("sh_acc_stall", 32'(lsu_stall), 32'd1);
        cyc(1'b1, 1'b1, 3'd1, 32'h202, 32'h1234_5678, 1'b1, 1'b0, 32'd0);
        check("sh_req", 32'(d_req), 32'd1);
        check("sh_we", 32'(d_we), 32'd1);
        check("sh_be", 32'(d_be), 32'hC);
        check("sh_wdata", d_wdata, 32'h5678_5678);
        check("sh_addr", d_addr, 32'h200);
        check("sh_stall", 32'(lsu_stall), 32'd0);
        check("sh_data", lsu_data, 32'd0);
        idle_cyc();
        check("sh_idle_req", 32'(d_req), 32'd0);

        // SB 0x002 data 0xAB
        cyc(1'b1, 1'b1, 3'd0, 32'h002, 32'h0000_00AB, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 3'd0, 32'h002, 32'h0000_00AB, 1'b1, 1'b0, 32'd0);
        check("sb_be", 32'(d_be), 32'h4);
        check("sb_wdata", d_wdata, 32'hABAB_ABAB);
        check("sb_stall", 32'(lsu_stall), 32'd0);
        idle_cyc();

        // LBU 0x001: gnt and rvalid together
        cyc(1'b1, 1'b0, 3'd4, 32'h001, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 3'd4, 32'h001, 32'd0, 1'b1, 1'b1, 32'h0000_8000);
        check("lbu_be", 32'(d_be), 32'h2);
        check("lbu_data", lsu_data, 32'h0000_0080);
        check("lbu_stall", 32'(lsu_stall), 32'd0);
        idle_cyc();

        // LH 0x000 sign extension
        cyc(1'b1, 1'b0, 3'd1, 32'h000, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 3'd1, 32'h000, 32'd0, 1'b1, 1'b1, 32'h7777_8001);
        check("lh_be", 32'(d_be), 32'h3);
        check("lh_data", lsu_data, 32'hFFFF_8001);
        idle_cyc();

        // Faulting requests: no bus access, fault pulse, no stall
        cyc(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 1'b0, 1'b0, 32'd0);
        check("lw_mis_fault", 32'(lsu_fault), 32'd1);
        check("lw_mis_code", 32'(lsu_code), 32'd1);
        check("lw_mis_stall", 32'(lsu_stall), 32'd0);
        idle_cyc();
        check("lw_mis_noreq", 32'(d_req), 32'd0);
        check("lw_mis_pulse", 32'(lsu_fault), 32'd0);
        cyc(1'b1, 1'b1, 3'd5, 32'h000, 32'd0, 1'b0, 1'b0, 32'd0);
        check("sb5_code", 32'(lsu_code), 32'd2);
        check("sb5_fault", 32'(lsu_fault), 32'd1);
        cyc(1'b1, 1'b0, 3'd3, 32'h000, 32'd0, 1'b0, 1'b0, 32'd0);
        check("sz3_code", 32'(lsu_code), 32'd2);
        cyc(1'b1, 1'b0, 3'd1, 32'h001, 32'd0, 1'b0, 1'b0, 32'd0);
        check("lh_mis_code", 32'(lsu_code), 32'd1);
        cyc(1'b1, 1'b1, 3'd5, 32'h001, 32'd0, 1'b0, 1'b0, 32'd0);
        check("prio_code", 32'(lsu_code), 32'd2);
        idle_cyc();
        check("fault_noreq", 32'(d_req), 32'd0);

        // LHU 0x002 with gnt delayed 3 cycles
        cyc(1'b1, 1'b0, 3'd5, 32'h002, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 3'd5, 32'h002, 32'd0, 1'b0, 1'b0, 32'd0);
            check("lhu_hold_req", 32'(d_req), 32'd1);
            check("lhu_hold_addr", d_addr, 32'h0);
            check("lhu_hold_be", 32'(d_be), 32'hC);
            check("lhu_hold_stall", 32'(lsu_stall), 32'd1);
        end
        cyc(1'b1, 1'b0, 3'd5, 32'h002, 32'd0, 1'b1, 1'b1, 32'hBEEF_0000);
        check("lhu_data", lsu_data, 32'h0000_BEEF);
        check("lhu_stall", 32'(lsu_stall), 32'd0);
        idle_cyc();

        // LW timeout: gnt, then no rvalid; abort on the 16th cycle after accept
        cyc(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 1'b1, 1'b0, 32'd0);
        for (int i = 2; i < 16; i++) begin
            cyc(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0);
            check("to_wait_stall", 32'(lsu_stall), 32'd1);
            check("to_wait_fault", 32'(lsu_fault), 32'd0);
        end
        cyc(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0);
        check("to_fault", 32'(lsu_fault), 32'd1);
        check("to_code", 32'(lsu_code), 32'd3);
        check("to_stall", 32'(lsu_stall), 32'd0);
        check("to_req", 32'(d_req), 32'd0);
        check("to_data", lsu_data, 32'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1234_5678);
        check("late_rv_data", lsu_data, 32'd0);
        check("late_rv_fault", 32'(lsu_fault), 32'd0);
        idle_cyc();
        check("late_rv_req", 32'(d_req), 32'd0);

        // Reset asserted while in WAIT
        cyc(1'b1, 1'b0, 3'd2, 32'h010, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 3'd2, 32'h010, 32'd0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        idle_cyc();
        check_reset_outputs("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("rst_late_rv", lsu_data, 32'd0);

        // Back-to-back LW then SW with lsu_req held high
        cyc(1'b1, 1'b0, 3'd2, 32'h020, 32'd0, 1'b0, 1'b0, 32'd0);
        check("b2b_lw_acc", 32'(lsu_stall), 32'd1);
        cyc(1'b1, 1'b0, 3'd2, 32'h020, 32'd0, 1'b1, 1'b1, 32'hCAFE_F00D);
        check("b2b_lw_req", 32'(d_req), 32'd1);
        check("b2b_lw_data", lsu_data, 32'hCAFE_F00D);
        check("b2b_lw_stall", 32'(lsu_stall), 32'd0);
        cyc(1'b1, 1'b1, 3'd2, 32'h024, 32'h1122_3344, 1'b0, 1'b0, 32'd0);
        check("b2b_sw_acc_req", 32'(d_req), 32'd0);
        check("b2b_sw_acc_stall", 32'(lsu_stall), 32'd1);
        cyc(1'b1, 1'b1, 3'd2, 32'h024, 32'h1122_3344, 1'b1, 1'b0, 32'd0);
        check("b2b_sw_req", 32'(d_req), 32'd1);
        check("b2b_sw_addr", d_addr, 32'h024);
        check("b2b_sw_be", 32'(d_be), 32'hF);
        check("b2b_sw_wdata", d_wdata, 32'h1122_3344);
        check("b2b_sw_stall", 32'(lsu_stall), 32'd0);
        idle_cyc();
        check("b2b_end_req", 32'(d_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
